pipeline_ctrl: RTL
==================

// Module: pipeline_ctrl
// PURPOSE
// - Drives the load/flush controls of the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
// - Combines three sources: memory-stall handshakes (imem/dmem resp), load-use hazards (ID/EX load vs IF/ID sources)
//   and control redirects (taken branch/jump) into one consistent freeze/bubble/flush decision per cycle.
// - Keeps saturating performance counters for stall, bubble and flush events.
// PARAMETERS
// - CNT_WIDTH   32  width of each performance counter
// - LU_BUBBLES  1   bubble cycles inserted per load-use hazard; legal range 1..3
// PORTS
// - clk            in   1          clock, all state on posedge
// - rst            in   1          synchronous, active-high reset
// - imem_read      in   1          IF stage has an instruction fetch outstanding
// - imem_resp      in   1          instruction memory response, valid this cycle
// - dmem_read      in   1          MEM stage load request (from EX/MEM control word)
// - dmem_write     in   1          MEM stage store request
// - dmem_resp      in   1          data memory response, valid this cycle
// - idex_is_load   in   1          instruction in ID/EX is a load
// - idex_rd        in   5          destination register of ID/EX instruction
// - ifid_rs1       in   5          rs1 of instruction in IF/ID
// - ifid_rs2       in   5          rs2 of instruction in IF/ID
// - ifid_use_rs1   in   1          IF/ID instruction reads rs1
// - ifid_use_rs2   in   1          IF/ID instruction reads rs2
// - br_taken       in   1          redirect resolved in EX/MEM; PC mux selects the target this cycle
// - load_pc        out  1          PC register write enable
// - load_if_id     out  1          IF/ID load
// - load_id_ex     out  1          ID/EX load
// - load_ex_mem    out  1          EX/MEM load
// - load_mem_wb    out  1          MEM/WB load
// - flush_if_id    out  1          IF/ID captures NOP 32'h00000013 on load
// - flush_id_ex    out  1          ID/EX captures a zeroed control word on load
// - stall_cnt      out  CNT_WIDTH  cycles spent with mem_stall=1
// - bubble_cnt     out  CNT_WIDTH  load-use bubble cycles inserted
// - flush_cnt      out  CNT_WIDTH  redirect events applied
// BEHAVIOUR
// - Definitions:
//   - mem_stall = (imem_read & ~imem_resp) | ((dmem_read | dmem_write) & ~dmem_resp).
//   - lu_haz = idex_is_load & (idex_rd != 0) & ((ifid_use_rs1 & ifid_rs1 == idex_rd) | (ifid_use_rs2 & ifid_rs2 == idex_rd)).
// - Reset: state=RUN, bub_left=0, all counters 0. While rst=1: all load_*=0, flush_*=0.
// - Control outputs are combinational from state and inputs (zero latency). Counters update on the next posedge.
// - Priority, highest first: mem_stall > br_taken > bubble (lu_haz or state BUBBLE) > normal.
//   - mem_stall: all load_*=0, flush_*=0. stall_cnt+1.
//     - Enter/stay MEM_WAIT. ret_state and bub_left are held.
//     - br_taken is held stable by the frozen EX/MEM and is applied on the release cycle.
//   - br_taken, no stall: all load_*=1, flush_if_id=1, flush_id_ex=1. flush_cnt+1.
//     - Any pending bubble is aborted: state=RUN, bub_left=0.
//   - Bubble: load_pc=0, load_if_id=0, load_id_ex=1 with flush_id_ex=1, load_ex_mem=load_mem_wb=1. bubble_cnt+1.
//     - From RUN with lu_haz: if LU_BUBBLES>1, go to BUBBLE with bub_left=LU_BUBBLES-1; else stay RUN.
//     - In BUBBLE: bub_left-1; return to RUN on the cycle bub_left==1.
//   - Normal: all load_*=1, flush_*=0.
// - FSM states: RUN, BUBBLE, MEM_WAIT.
//   - MEM_WAIT returns to ret_state (RUN or BUBBLE) on the first cycle mem_stall=0.
//   - That release cycle is evaluated with the full priority list above.
// - lu_haz while in BUBBLE does not restart the count.
// - Counters saturate at all-ones and never wrap.
// - Simultaneous br_taken and lu_haz: the redirect wins; no bubble is counted.
// - rst asserted mid-stall or mid-bubble: the next cycle is RUN with counters 0.
// STRUCTURE
// - rv32i_types gains pipe_ctrl_state_t enum {RUN, BUBBLE, MEM_WAIT} and localparam NOP_INSTR = 32'h00000013.
// - Sub-module hazard_detect: combinational lu_haz compare; reused by the forwarding unit.
// - Counters are a generic sat_counter instance x3.
// TESTING
// - Fetch stall: imem_read=1, imem_resp=0 for 4 cycles, then 1.
//   -> all loads 0 for 4 cycles, 1 on cycle 5; stall_cnt=4.
// - Load-use: idex_is_load=1, idex_rd=5, ifid_rs1=5, use_rs1=1 for 1 cycle.
//   -> load_pc=load_if_id=0, flush_id_ex=1; bubble_cnt=1; next cycle normal.
// - rd=x0: idex_rd=0, ifid_rs1=0 -> no bubble; bubble_cnt stays 0.
// - Redirect with hazard: br_taken=1 and lu_haz=1 in the same cycle.
//   -> all loads 1, both flushes 1; flush_cnt=1; bubble_cnt=0.
// - Stall during bubble (LU_BUBBLES=3): dmem_read=1 with no resp for 2 cycles in BUBBLE, bub_left=2.
//   -> freeze 2 cycles, then exactly 2 more bubbles; bubble_cnt=3.
// - Saturation (CNT_WIDTH=4): hold mem_stall 20 cycles -> stall_cnt=15, no wrap. Then rst for 1 cycle -> all counters 0, state RUN.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline control block: controller FSM states and the
// canonical NOP (addi x0,x0,0) that IF/ID captures when it is flushed.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN,
    BUBBLE,
    MEM_WAIT
  } pipe_ctrl_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Handshake and control bundle between the pipeline datapath (master) and the
// pipeline controller (slave).
interface pipeline_ctrl_if;

  logic       imem_read;
  logic       imem_resp;
  logic       dmem_read;
  logic       dmem_write;
  logic       dmem_resp;
  logic       idex_is_load;
  logic [4:0] idex_rd;
  logic [4:0] ifid_rs1;
  logic [4:0] ifid_rs2;
  logic       ifid_use_rs1;
  logic       ifid_use_rs2;
  logic       br_taken;
  logic       load_pc;
  logic       load_if_id;
  logic       load_id_ex;
  logic       load_ex_mem;
  logic       load_mem_wb;
  logic       flush_if_id;
  logic       flush_id_ex;

  modport master (
    output imem_read, imem_resp, dmem_read, dmem_write, dmem_resp,
           idex_is_load, idex_rd, ifid_rs1, ifid_rs2, ifid_use_rs1, ifid_use_rs2,
           br_taken,
    input  load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
           flush_if_id, flush_id_ex
  );

  modport slave (
    input  imem_read, imem_resp, dmem_read, dmem_write, dmem_resp,
           idex_is_load, idex_rd, ifid_rs1, ifid_rs2, ifid_use_rs1, ifid_use_rs2,
           br_taken,
    output load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
           flush_if_id, flush_id_ex
  );

endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard compare between the load in ID/EX and the sources of IF/ID.
// Kept standalone so the forwarding unit can share the same compare.
module hazard_detect (
  input  logic       idex_is_load,
  input  logic [4:0] idex_rd,
  input  logic [4:0] ifid_rs1,
  input  logic [4:0] ifid_rs2,
  input  logic       ifid_use_rs1,
  input  logic       ifid_use_rs2,
  output logic       lu_haz
);

  logic rs1_hit;
  logic rs2_hit;

  // x0 is never a real producer, so a load targeting it cannot cause a hazard
  always_comb begin
    rs1_hit = ifid_use_rs1 && (ifid_rs1 == idex_rd);
    rs2_hit = ifid_use_rs2 && (ifid_rs2 == idex_rd);
    lu_haz  = idex_is_load && (idex_rd != 5'd0) && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/pipeline_ctrl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] count_q;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Per-cycle freeze/bubble/flush decision for the four pipeline registers and PC,
// plus saturating stall/bubble/flush event counters.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH  = 32,
  parameter int LU_BUBBLES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  pipeline_ctrl_if.slave       bus,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] bubble_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt
);

  pipe_ctrl_state_t state_q, state_d;
  pipe_ctrl_state_t ret_state_q, ret_state_d;
  pipe_ctrl_state_t eff_state;
  logic [1:0]       bub_left_q, bub_left_d;
  logic             mem_stall;
  logic             lu_haz;
  logic             stall_inc, bubble_inc, flush_inc;

  hazard_detect u_hazard (
    .idex_is_load (bus.idex_is_load),
    .idex_rd      (bus.idex_rd),
    .ifid_rs1     (bus.ifid_rs1),
    .ifid_rs2     (bus.ifid_rs2),
    .ifid_use_rs1 (bus.ifid_use_rs1),
    .ifid_use_rs2 (bus.ifid_use_rs2),
    .lu_haz       (lu_haz)
  );

  // The release cycle out of MEM_WAIT behaves as the state we were frozen in
  always_comb begin
    mem_stall = (bus.imem_read && !bus.imem_resp) ||
                ((bus.dmem_read || bus.dmem_write) && !bus.dmem_resp);
    eff_state = (state_q == MEM_WAIT) ? ret_state_q : state_q;

    state_d          = state_q;
    ret_state_d      = ret_state_q;
    bub_left_d       = bub_left_q;
    stall_inc        = 1'b0;
    bubble_inc       = 1'b0;
    flush_inc        = 1'b0;
    bus.load_pc      = 1'b1;
    bus.load_if_id   = 1'b1;
    bus.load_id_ex   = 1'b1;
    bus.load_ex_mem  = 1'b1;
    bus.load_mem_wb  = 1'b1;
    bus.flush_if_id  = 1'b0;
    bus.flush_id_ex  = 1'b0;

    if (rst) begin
      bus.load_pc     = 1'b0;
      bus.load_if_id  = 1'b0;
      bus.load_id_ex  = 1'b0;
      bus.load_ex_mem = 1'b0;
      bus.load_mem_wb = 1'b0;
    end else if (mem_stall) begin
      bus.load_pc     = 1'b0;
      bus.load_if_id  = 1'b0;
      bus.load_id_ex  = 1'b0;
      bus.load_ex_mem = 1'b0;
      bus.load_mem_wb = 1'b0;
      stall_inc       = 1'b1;
      state_d         = MEM_WAIT;
      if (state_q != MEM_WAIT) begin
        ret_state_d = state_q;
      end
    end else if (bus.br_taken) begin
      bus.flush_if_id = 1'b1;
      bus.flush_id_ex = 1'b1;
      flush_inc       = 1'b1;
      state_d         = RUN;
      bub_left_d      = 2'd0;
    end else if ((eff_state == BUBBLE) || lu_haz) begin
      bus.load_pc     = 1'b0;
      bus.load_if_id  = 1'b0;
      bus.flush_id_ex = 1'b1;
      bubble_inc      = 1'b1;
      if (eff_state == BUBBLE) begin
        if (bub_left_q == 2'd1) begin
          state_d    = RUN;
          bub_left_d = 2'd0;
        end else begin
          state_d    = BUBBLE;
          bub_left_d = bub_left_q - 2'd1;
        end
      end else if (LU_BUBBLES > 1) begin
        state_d    = BUBBLE;
        bub_left_d = 2'(LU_BUBBLES - 1);
      end else begin
        state_d = RUN;
      end
    end else begin
      state_d = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      ret_state_q <= RUN;
      bub_left_q  <= 2'd0;
    end else begin
      state_q     <= state_d;
      ret_state_q <= ret_state_d;
      bub_left_q  <= bub_left_d;
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (bubble_inc),
    .count (bubble_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

endmodule
